mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access.sv | 188 ++++++++++++++++++
 tb/tb_mem_access.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// Load/store unit: one outstanding data-memory access, ALU writeback passthrough,
// misalign/illegal detection. All outputs come straight from flops.
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_load,
  input  logic        in_store,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_reg_addr,
  input  logic [31:0] in_reg_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        fault,
  output logic [31:0] fault_addr
);

  typedef enum logic {IDLE, BUSY} state_e;

  typedef struct packed {
    logic       load;
    logic [2:0] funct3;
    logic [1:0] off;
    logic [4:0] rd;
  } op_t;

  state_e      state_q, state_d;
  op_t         op_q, op_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        wbv_q, wbv_d;
  logic [4:0]  wba_q, wba_d;
  logic [31:0] wbd_q, wbd_d;
  logic        flt_q, flt_d;
  logic [31:0] fa_q, fa_d;

  logic        ld_ok, st_ok, mis, legal;
  logic [31:0] st_data;
  logic [3:0]  st_strb;
  logic [31:0] sh;
  logic [31:0] ld_ext;

  assign ld_ok = (in_funct3[1:0] != 2'b11) && !(in_funct3[2] && in_funct3[1]);
  assign st_ok = !in_funct3[2] && (in_funct3[1:0] != 2'b11);
  assign mis   = (in_funct3[1:0] == 2'b01 && in_addr[0])
              || (in_funct3[1:0] == 2'b10 && in_addr[1:0] != 2'b00);
  assign legal = (in_load ^ in_store) && (in_load ? ld_ok : st_ok) && !mis;

  always_comb begin
    st_data = in_wdata;
    st_strb = 4'b1111;
    unique case (1'b1)
      in_funct3[1:0] == 2'b00: begin
        st_data = {4{in_wdata[7:0]}};
        st_strb = 4'b0001 << in_addr[1:0];
      end
      in_funct3[1:0] == 2'b01: begin
        st_data = {2{in_wdata[15:0]}};
        st_strb = 4'b0011 << {in_addr[1], 1'b0};
      end
      default: ;
    endcase
  end

  // Halves are aligned, so a byte-lane shift serves both sizes.
  assign sh = dmem_rdata >> {op_q.off, 3'b000};

  always_comb begin
    ld_ext = dmem_rdata;
    unique case (op_q.funct3)
      3'b000:  ld_ext = {{24{sh[7]}}, sh[7:0]};
      3'b001:  ld_ext = {{16{sh[15]}}, sh[15:0]};
      3'b100:  ld_ext = {24'b0, sh[7:0]};
      3'b101:  ld_ext = {16'b0, sh[15:0]};
      default: ld_ext = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    wbv_d   = 1'b0;
    wba_d   = wba_q;
    wbd_d   = wbd_q;
    flt_d   = 1'b0;
    fa_d    = fa_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (!in_load && !in_store) begin
            wbv_d = |in_reg_addr;
            wba_d = in_reg_addr;
            wbd_d = in_reg_data;
          end else if (!legal) begin
            flt_d = 1'b1;
            fa_d  = in_addr;
          end else begin
            state_d = BUSY;
            req_d   = 1'b1;
            we_d    = in_store;
            addr_d  = {in_addr[31:2], 2'b00};
            wdata_d = in_store ? st_data : 32'b0;
            wstrb_d = in_store ? st_strb : 4'b0;
            op_d    = '{load: in_load, funct3: in_funct3,
                        off: in_addr[1:0], rd: in_rd};
          end
        end
      end
      BUSY: begin
        if (dmem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          wstrb_d = 4'b0;
          if (op_q.load) begin
            wbv_d = |op_q.rd;
            wba_d = op_q.rd;
            wbd_d = ld_ext;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      wbv_q   <= 1'b0;
      wba_q   <= '0;
      wbd_q   <= '0;
      flt_q   <= 1'b0;
      fa_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      wbv_q   <= wbv_d;
      wba_q   <= wba_d;
      wbd_q   <= wbd_d;
      flt_q   <= flt_d;
      fa_q    <= fa_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign dmem_wstrb = wstrb_q;
  assign wb_valid   = wbv_q;
  assign wb_addr    = wba_q;
  assign wb_data    = wbd_q;
  assign fault      = flt_q;
  assign fault_addr = fa_q;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed scenarios plus randomized ops
// against an arithmetic reference model.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_load, in_store;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_wdata, in_reg_data;
  logic [4:0]  in_rd, in_reg_addr;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic        wb_valid, fault;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data, fault_addr;

  int n_tot  = 0;
  int n_pass = 0;

  mem_access dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_load(in_load), .in_store(in_store),
    .in_funct3(in_funct3), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_rd(in_rd),
    .in_reg_addr(in_reg_addr), .in_reg_data(in_reg_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .fault(fault), .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic ld, input logic st,
                          input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] rd,
                          input logic [4:0] ra, input logic [31:0] rdat);
    in_load = ld; in_store = st; in_funct3 = f3; in_addr = a;
    in_wdata = wd; in_rd = rd; in_reg_addr = ra; in_reg_data = rdat;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Reference model: access rules in plain arithmetic.
  function automatic logic mdl_legal(input logic ld, input logic st,
                                     input int f3, input logic [31:0] a);
    int sz;
    sz = f3 % 4;
    if (ld == st) return 1'b0;
    if (ld && !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5)) return 1'b0;
    if (st && !(f3 == 0 || f3 == 1 || f3 == 2)) return 1'b0;
    if (sz == 1 && (a % 2) != 0) return 1'b0;
    if (sz == 2 && (a % 4) != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] mdl_load(input int f3, input logic [31:0] a,
                                           input logic [31:0] rd);
    int unsigned lane, b, h;
    lane = a % 4;
    b = (rd / (1 << (8 * lane))) % 256;
    h = (rd / (1 << (16 * (lane / 2)))) % 65536;
    case (f3)
      0: return (b >= 128) ? 32'(b) + 32'hFFFFFF00 : 32'(b);
      1: return (h >= 32768) ? 32'(h) + 32'hFFFF0000 : 32'(h);
      4: return 32'(b);
      5: return 32'(h);
      default: return rd;
    endcase
  endfunction

  function automatic logic [3:0] mdl_strb(input int f3, input logic [31:0] a);
    case (f3)
      0: return 4'(1 << (a % 4));
      1: return 4'(3 << (a % 4));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] mdl_wdata(input int f3, input logic [31:0] wd);
    case (f3)
      0: return (wd % 256) * 32'h01010101;
      1: return (wd % 65536) * 32'h00010001;
      default: return wd;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    n_tot++; if (dmem_req !== 1'b0) $display("FAIL rst_req got %0h exp 0", dmem_req); else n_pass++;
    n_tot++; if (dmem_we !== 1'b0) $display("FAIL rst_we got %0h exp 0", dmem_we); else n_pass++;
    n_tot++; if (dmem_wstrb !== 4'h0) $display("FAIL rst_wstrb got %0h exp 0", dmem_wstrb); else n_pass++;
    n_tot++; if (wb_valid !== 1'b0) $display("FAIL rst_wbv got %0h exp 0", wb_valid); else n_pass++;
    n_tot++; if (wb_addr !== 5'd0) $display("FAIL rst_wba got %0h exp 0", wb_addr); else n_pass++;
    n_tot++; if (fault !== 1'b0) $display("FAIL rst_fault got %0h exp 0", fault); else n_pass++;
    n_tot++; if (dmem_addr !== 32'h0) $display("FAIL rst_addr got %0h exp 0", dmem_addr); else n_pass++;
    n_tot++; if (dmem_wdata !== 32'h0) $display("FAIL rst_wdata got %0h exp 0", dmem_wdata); else n_pass++;
    n_tot++; if (wb_data !== 32'h0) $display("FAIL rst_wbd got %0h exp 0", wb_data); else n_pass++;
    n_tot++; if (fault_addr !== 32'h0) $display("FAIL rst_faddr got %0h exp 0", fault_addr); else n_pass++;
    rst = 1'b1;
    tick();
    n_tot++; if (in_ready !== 1'b1) $display("FAIL rst_ready got %0h exp 1", in_ready); else n_pass++;
  endtask

  task automatic test_alu();
    drive_op(0, 0, 3'd0, 32'h0, 32'h0, 5'd0, 5'd5, 32'hDEADBEEF);
    n_tot++; if (wb_valid !== 1'b1) $display("FAIL alu_wbv got %0h exp 1", wb_valid); else n_pass++;
    n_tot++; if (wb_addr !== 5'd5) $display("FAIL alu_wba got %0h exp 5", wb_addr); else n_pass++;
    n_tot++; if (wb_data !== 32'hDEADBEEF) $display("FAIL alu_wbd got %0h exp deadbeef", wb_data); else n_pass++;
    n_tot++; if (in_ready !== 1'b1) $display("FAIL alu_ready got %0h exp 1", in_ready); else n_pass++;
    tick();
    n_tot++; if (wb_valid !== 1'b0) $display("FAIL alu_pulse got %0h exp 0", wb_valid); else n_pass++;
    drive_op(0, 0, 3'd0, 32'h0, 32'h0, 5'd0, 5'd0, 32'hDEADBEEF);
    n_tot++; if (wb_valid !== 1'b0) $display("FAIL alu_x0 got %0h exp 0", wb_valid); else n_pass++;
  endtask

  task automatic test_load();
    int hi;
    logic [31:0] exp_v [2];
    exp_v[0] = 32'hFFFFFF80;
    exp_v[1] = 32'h00000080;
    for (int k = 0; k < 2; k++) begin
      drive_op(1, 0, (k == 0) ? 3'b000 : 3'b100, 32'h1003, 32'h0, 5'd3, 5'd0, 32'h0);
      dmem_rdata = 32'h80FF_0000;
      n_tot++; if (dmem_addr !== 32'h1000) $display("FAIL ld_addr got %0h exp 1000", dmem_addr); else n_pass++;
      n_tot++; if (dmem_we !== 1'b0) $display("FAIL ld_we got %0h exp 0", dmem_we); else n_pass++;
      n_tot++; if (dmem_wstrb !== 4'h0) $display("FAIL ld_wstrb got %0h exp 0", dmem_wstrb); else n_pass++;
      hi = 0;
      for (int c = 0; c < 8 && dmem_req === 1'b1; c++) begin
        hi++;
        dmem_ack = (hi == 3);
        tick();
      end
      dmem_ack = 1'b0;
      n_tot++; if (hi != 3) $display("FAIL ld_req_cycles got %0d exp 3", hi); else n_pass++;
      n_tot++; if (wb_valid !== 1'b1) $display("FAIL ld_wbv got %0h exp 1", wb_valid); else n_pass++;
      n_tot++; if (wb_addr !== 5'd3) $display("FAIL ld_wba got %0h exp 3", wb_addr); else n_pass++;
      n_tot++; if (wb_data !== exp_v[k]) $display("FAIL ld_wbd got %0h exp %0h", wb_data, exp_v[k]); else n_pass++;
      tick();
    end
  endtask

  task automatic test_store();
    drive_op(0, 1, 3'b001, 32'h2002, 32'h1234ABCD, 5'd9, 5'd0, 32'h0);
    n_tot++; if (dmem_req !== 1'b1) $display("FAIL st_req got %0h exp 1", dmem_req); else n_pass++;
    n_tot++; if (dmem_we !== 1'b1) $display("FAIL st_we got %0h exp 1", dmem_we); else n_pass++;
    n_tot++; if (dmem_wstrb !== 4'b1100) $display("FAIL st_wstrb got %0h exp c", dmem_wstrb); else n_pass++;
    n_tot++; if (dmem_wdata !== 32'hABCDABCD) $display("FAIL st_wdata got %0h exp abcdabcd", dmem_wdata); else n_pass++;
    n_tot++; if (in_ready !== 1'b0) $display("FAIL st_busy got %0h exp 0", in_ready); else n_pass++;
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    n_tot++; if (dmem_req !== 1'b0) $display("FAIL st_req_drop got %0h exp 0", dmem_req); else n_pass++;
    n_tot++; if (wb_valid !== 1'b0) $display("FAIL st_nowb got %0h exp 0", wb_valid); else n_pass++;
    n_tot++; if (in_ready !== 1'b1) $display("FAIL st_ready got %0h exp 1", in_ready); else n_pass++;
  endtask

  task automatic test_fault();
    drive_op(1, 0, 3'b010, 32'h3001, 32'h0, 5'd4, 5'd0, 32'h0);
    n_tot++; if (fault !== 1'b1) $display("FAIL flt_mis got %0h exp 1", fault); else n_pass++;
    n_tot++; if (fault_addr !== 32'h3001) $display("FAIL flt_addr got %0h exp 3001", fault_addr); else n_pass++;
    n_tot++; if (dmem_req !== 1'b0) $display("FAIL flt_req got %0h exp 0", dmem_req); else n_pass++;
    n_tot++; if (wb_valid !== 1'b0) $display("FAIL flt_wbv got %0h exp 0", wb_valid); else n_pass++;
    tick();
    n_tot++; if (fault !== 1'b0) $display("FAIL flt_pulse got %0h exp 0", fault); else n_pass++;
    drive_op(1, 0, 3'b011, 32'h3000, 32'h0, 5'd4, 5'd0, 32'h0);
    n_tot++; if (fault !== 1'b1) $display("FAIL flt_f3 got %0h exp 1", fault); else n_pass++;
    n_tot++; if (dmem_req !== 1'b0) $display("FAIL flt_f3_req got %0h exp 0", dmem_req); else n_pass++;
    drive_op(1, 1, 3'b010, 32'h3004, 32'h0, 5'd4, 5'd0, 32'h0);
    n_tot++; if (fault !== 1'b1) $display("FAIL flt_both got %0h exp 1", fault); else n_pass++;
    tick();
  endtask

  task automatic test_reset_busy();
    int wbs;
    wbs = 0;
    drive_op(1, 0, 3'b010, 32'h4000, 32'h0, 5'd6, 5'd0, 32'h0);
    dmem_rdata = 32'h11223344;
    tick();
    rst = 1'b0;
    dmem_ack = 1'b1;
    tick();
    n_tot++; if (dmem_req !== 1'b0) $display("FAIL rb_req got %0h exp 0", dmem_req); else n_pass++;
    if (wb_valid === 1'b1) wbs++;
    rst = 1'b1;
    tick();
    if (wb_valid === 1'b1) wbs++;
    n_tot++; if (in_ready !== 1'b1) $display("FAIL rb_ready got %0h exp 1", in_ready); else n_pass++;
    dmem_ack = 1'b0;
    tick();
    if (wb_valid === 1'b1) wbs++;
    n_tot++; if (wbs != 0) $display("FAIL rb_nowb got %0d exp 0", wbs); else n_pass++;
    n_tot++; if (dmem_req !== 1'b0) $display("FAIL rb_req2 got %0h exp 0", dmem_req); else n_pass++;
  endtask

  task automatic test_back_to_back();
    in_load = 1; in_store = 0; in_funct3 = 3'b010; in_addr = 32'h5000;
    in_rd = 5'd7; in_valid = 1'b1;
    tick();
    in_load = 0; in_reg_addr = 5'd9; in_reg_data = 32'hCAFEF00D;
    tick();
    n_tot++; if (wb_valid !== 1'b0) $display("FAIL b2b_early got %0h exp 0", wb_valid); else n_pass++;
    n_tot++; if (in_ready !== 1'b0) $display("FAIL b2b_busy got %0h exp 0", in_ready); else n_pass++;
    dmem_ack = 1'b1; dmem_rdata = 32'h0BADF00D;
    tick();
    dmem_ack = 1'b0;
    n_tot++; if (wb_valid !== 1'b1 || wb_addr !== 5'd7) $display("FAIL b2b_first got %0h/%0h exp 1/7", wb_valid, wb_addr); else n_pass++;
    n_tot++; if (wb_data !== 32'h0BADF00D) $display("FAIL b2b_first_d got %0h exp badf00d", wb_data); else n_pass++;
    tick();
    in_valid = 1'b0;
    n_tot++; if (wb_valid !== 1'b1 || wb_addr !== 5'd9) $display("FAIL b2b_second got %0h/%0h exp 1/9", wb_valid, wb_addr); else n_pass++;
    n_tot++; if (wb_data !== 32'hCAFEF00D) $display("FAIL b2b_second_d got %0h exp cafef00d", wb_data); else n_pass++;
    tick();
    n_tot++; if (wb_valid !== 1'b0) $display("FAIL b2b_pulse got %0h exp 0", wb_valid); else n_pass++;
  endtask

  task automatic test_random();
    logic        ld, st, lg, exp_wbv;
    int          f3, w, kind;
    logic [31:0] a, wd, rdat, ev;
    logic [4:0]  rd, ra;
    for (int it = 0; it < 80; it++) begin
      kind = $urandom_range(0, 9);
      ld = (kind < 4) || (kind == 9);
      st = (kind >= 4 && kind < 8) || (kind == 9);
      f3 = $urandom_range(0, 7);
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a - (a % 4) + 4 * $urandom_range(0, 1) + ((f3 % 4 == 0) ? a % 4 : 0);
      wd = $urandom; rdat = $urandom;
      rd = 5'($urandom); ra = 5'($urandom);
      w = $urandom_range(0, 3);
      lg = mdl_legal(ld, st, f3, a);
      n_tot++; if (in_ready !== 1'b1) $display("FAIL rnd_ready it=%0d got %0h exp 1", it, in_ready); else n_pass++;
      dmem_ack = $urandom_range(0, 1);
      drive_op(ld, st, 3'(f3), a, wd, rd, ra, rdat);
      dmem_ack = 1'b0;
      if (!ld && !st) begin
        exp_wbv = (ra != 0);
        n_tot++; if (wb_valid !== exp_wbv) $display("FAIL rnd_alu_wbv it=%0d got %0h exp %0h", it, wb_valid, exp_wbv); else n_pass++;
        n_tot++; if (exp_wbv && (wb_addr !== ra || wb_data !== rdat)) $display("FAIL rnd_alu_wb it=%0d got %0h:%0h exp %0h:%0h", it, wb_addr, wb_data, ra, rdat); else n_pass++;
        n_tot++; if (dmem_req !== 1'b0) $display("FAIL rnd_alu_req it=%0d got %0h exp 0", it, dmem_req); else n_pass++;
      end else if (!lg) begin
        n_tot++; if (fault !== 1'b1 || fault_addr !== a) $display("FAIL rnd_fault it=%0d got %0h:%0h exp 1:%0h", it, fault, fault_addr, a); else n_pass++;
        n_tot++; if (dmem_req !== 1'b0 || wb_valid !== 1'b0) $display("FAIL rnd_fault_side it=%0d got %0h/%0h exp 0/0", it, dmem_req, wb_valid); else n_pass++;
      end else begin
        n_tot++; if (dmem_req !== 1'b1 || dmem_we !== st || dmem_addr !== a - (a % 4)) $display("FAIL rnd_req it=%0d got %0h/%0h/%0h exp 1/%0h/%0h", it, dmem_req, dmem_we, dmem_addr, st, a - (a % 4)); else n_pass++;
        n_tot++; if (st && (dmem_wstrb !== mdl_strb(f3, a) || dmem_wdata !== mdl_wdata(f3, wd))) $display("FAIL rnd_st it=%0d got %0h:%0h exp %0h:%0h", it, dmem_wstrb, dmem_wdata, mdl_strb(f3, a), mdl_wdata(f3, wd)); else n_pass++;
        n_tot++; if (ld && (dmem_wstrb !== 4'h0 || dmem_wdata !== 32'h0)) $display("FAIL rnd_ld_w it=%0d got %0h:%0h exp 0:0", it, dmem_wstrb, dmem_wdata); else n_pass++;
        dmem_rdata = $urandom;
        for (int k = 0; k <= w; k++) begin
          n_tot++; if (dmem_req !== 1'b1) $display("FAIL rnd_hold it=%0d got %0h exp 1", it, dmem_req); else n_pass++;
          dmem_ack = (k == w);
          tick();
        end
        dmem_ack = 1'b0;
        ev = mdl_load(f3, a, dmem_rdata);
        exp_wbv = ld && (rd != 0);
        n_tot++; if (dmem_req !== 1'b0 || in_ready !== 1'b1) $display("FAIL rnd_done it=%0d got %0h/%0h exp 0/1", it, dmem_req, in_ready); else n_pass++;
        n_tot++; if (wb_valid !== exp_wbv) $display("FAIL rnd_wbv it=%0d got %0h exp %0h", it, wb_valid, exp_wbv); else n_pass++;
        n_tot++; if (exp_wbv && (wb_addr !== rd || wb_data !== ev)) $display("FAIL rnd_wb it=%0d got %0h:%0h exp %0h:%0h", it, wb_addr, wb_data, rd, ev); else n_pass++;
      end
      tick();
      n_tot++; if (wb_valid !== 1'b0 || fault !== 1'b0) $display("FAIL rnd_pulse it=%0d got %0h/%0h exp 0/0", it, wb_valid, fault); else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0;
    in_funct3 = '0; in_addr = '0; in_wdata = '0; in_rd = '0;
    in_reg_addr = '0; in_reg_data = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_fault();
    test_reset_busy();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
